// File: rtl/class_search_sched_if.sv
// Bundles the query stream, the shared class-ROM port, the per-class distance
// report and the result stream of class_search_sched.
//   master: encoder/ROM/consumer side (drives q_valid, q_frame, rom_data, res_ready)
//   slave : the sequencer (drives q_ready, ROM address, distance report, result, busy)
interface class_search_sched_if #(
    parameter int unsigned FRAME_W = 64,
    parameter int unsigned CID_W   = 3,
    parameter int unsigned FIDX_W  = 2,
    parameter int unsigned DIST_W  = 8
);
    logic               q_valid;
    logic               q_ready;
    logic [FRAME_W-1:0] q_frame;
    logic [CID_W-1:0]   frame_id;
    logic [FIDX_W-1:0]  frame_index;
    logic [FRAME_W-1:0] rom_data;
    logic               cls_dist_valid;
    logic [CID_W-1:0]   cls_dist_id;
    logic [DIST_W-1:0]  cls_dist;
    logic               res_valid;
    logic               res_ready;
    logic [CID_W-1:0]   res_class;
    logic [DIST_W-1:0]  res_dist;
    logic               busy;

    modport master (
        output q_valid, q_frame, rom_data, res_ready,
        input  q_ready, frame_id, frame_index, cls_dist_valid, cls_dist_id,
               cls_dist, res_valid, res_class, res_dist, busy
    );

    modport slave (
        input  q_valid, q_frame, rom_data, res_ready,
        output q_ready, frame_id, frame_index, cls_dist_valid, cls_dist_id,
               cls_dist, res_valid, res_class, res_dist, busy
    );
endinterface

// File: rtl/class_search_sched.sv
// Nearest-class search sequencer sharing the class hypervector ROM.
// Loads a query as N_FRAMES frames, sweeps every (class, frame) ROM address
// one per cycle accumulating Hamming distance, reports each class distance,
// then presents the minimum-distance class on the result handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : class_search_sched_if.slave (query in, ROM address/data,
//              per-class distance pulse, result out, busy)
module class_search_sched #(
    parameter int unsigned N_CLASSES = 8,
    parameter int unsigned N_FRAMES  = 3,
    parameter int unsigned FRAME_W   = 64,
    parameter int unsigned CID_W     = 3,
    parameter int unsigned FIDX_W    = 2,
    parameter int unsigned DIST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    class_search_sched_if.slave   bus
);
    localparam logic [FIDX_W-1:0] LAST_F = FIDX_W'(N_FRAMES - 1);
    localparam logic [CID_W-1:0]  LAST_C = CID_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t              state_q, state_d;
    logic [FIDX_W-1:0]   fcnt_q, fcnt_d;
    logic [CID_W-1:0]    ccnt_q, ccnt_d;
    logic [DIST_W-1:0]   acc_q, acc_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [CID_W-1:0]    best_cls_q, best_cls_d;
    logic [FRAME_W-1:0]  qbuf [N_FRAMES];
    logic                qbuf_we;
    logic [DIST_W-1:0]   pop, acc_next;

    // registered output state
    logic                q_ready_q, q_ready_d;
    logic                busy_q, busy_d;
    logic [CID_W-1:0]    frame_id_q, frame_id_d;
    logic [FIDX_W-1:0]   frame_index_q, frame_index_d;
    logic                cls_valid_q, cls_valid_d;
    logic [CID_W-1:0]    cls_id_q, cls_id_d;
    logic [DIST_W-1:0]   cls_dist_q, cls_dist_d;
    logic                res_valid_q, res_valid_d;
    logic [CID_W-1:0]    res_class_q, res_class_d;
    logic [DIST_W-1:0]   res_dist_q, res_dist_d;

    // next-state, datapath and next-output decode
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        ccnt_d      = ccnt_q;
        acc_d       = acc_q;
        best_dist_d = best_dist_q;
        best_cls_d  = best_cls_q;
        qbuf_we     = 1'b0;
        cls_valid_d = 1'b0;
        cls_id_d    = cls_id_q;
        cls_dist_d  = cls_dist_q;
        res_class_d = res_class_q;
        res_dist_d  = res_dist_q;
        pop         = DIST_W'($countones(bus.rom_data ^ qbuf[fcnt_q]));
        acc_next    = acc_q + pop;

        case (state_q)
            LOAD: begin
                if (bus.q_valid) begin
                    qbuf_we = 1'b1;
                    if (fcnt_q == LAST_F) begin
                        fcnt_d  = '0;
                        ccnt_d  = '0;
                        acc_d   = '0;
                        state_d = SCAN;
                    end else begin
                        fcnt_d = fcnt_q + FIDX_W'(1);
                    end
                end
            end
            SCAN: begin
                if (fcnt_q != LAST_F) begin
                    acc_d  = acc_next;
                    fcnt_d = fcnt_q + FIDX_W'(1);
                end else begin
                    cls_valid_d = 1'b1;
                    cls_id_d    = ccnt_q;
                    cls_dist_d  = acc_next;
                    acc_d       = '0;
                    fcnt_d      = '0;
                    // strict compare: ties keep the lower class id
                    if (ccnt_q == '0 || acc_next < best_dist_q) begin
                        best_dist_d = acc_next;
                        best_cls_d  = ccnt_q;
                    end
                    if (ccnt_q == LAST_C) begin
                        state_d     = DONE;
                        res_class_d = best_cls_d;
                        res_dist_d  = best_dist_d;
                    end else begin
                        ccnt_d = ccnt_q + CID_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = LOAD;
                    fcnt_d  = '0;
                    ccnt_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase

        // outputs are flopped from the next state so they line up with state_q
        q_ready_d     = (state_d == LOAD);
        busy_d        = (state_d != LOAD);
        res_valid_d   = (state_d == DONE);
        frame_id_d    = (state_d == SCAN) ? ccnt_d : '0;
        frame_index_d = (state_d == SCAN) ? fcnt_d : '0;
    end

    // state, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            fcnt_q        <= '0;
            ccnt_q        <= '0;
            acc_q         <= '0;
            best_dist_q   <= '0;
            best_cls_q    <= '0;
            q_ready_q     <= 1'b1;
            busy_q        <= 1'b0;
            frame_id_q    <= '0;
            frame_index_q <= '0;
            cls_valid_q   <= 1'b0;
            cls_id_q      <= '0;
            cls_dist_q    <= '0;
            res_valid_q   <= 1'b0;
            res_class_q   <= '0;
            res_dist_q    <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            ccnt_q        <= ccnt_d;
            acc_q         <= acc_d;
            best_dist_q   <= best_dist_d;
            best_cls_q    <= best_cls_d;
            q_ready_q     <= q_ready_d;
            busy_q        <= busy_d;
            frame_id_q    <= frame_id_d;
            frame_index_q <= frame_index_d;
            cls_valid_q   <= cls_valid_d;
            cls_id_q      <= cls_id_d;
            cls_dist_q    <= cls_dist_d;
            res_valid_q   <= res_valid_d;
            res_class_q   <= res_class_d;
            res_dist_q    <= res_dist_d;
        end
    end

    // query buffer has no reset; it is always fully rewritten before a scan
    always_ff @(posedge clk) begin
        if (qbuf_we) begin
            qbuf[fcnt_q] <= bus.q_frame;
        end
    end

    assign bus.q_ready        = q_ready_q;
    assign bus.busy           = busy_q;
    assign bus.frame_id       = frame_id_q;
    assign bus.frame_index    = frame_index_q;
    assign bus.cls_dist_valid = cls_valid_q;
    assign bus.cls_dist_id    = cls_id_q;
    assign bus.cls_dist       = cls_dist_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_class      = res_class_q;
    assign bus.res_dist       = res_dist_q;
endmodule

// File: tb/tb_class_search_sched.sv
// Directed testbench for class_search_sched with a stub class ROM whose
// per-class distances to the query are chosen by hand.
module tb_class_search_sched;
    localparam int unsigned N_CLASSES = 8;
    localparam int unsigned N_FRAMES  = 3;
    localparam int unsigned FRAME_W   = 64;
    localparam int unsigned CID_W     = 3;
    localparam int unsigned FIDX_W    = 2;
    localparam int unsigned DIST_W    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    class_search_sched_if #(.FRAME_W(FRAME_W), .CID_W(CID_W), .FIDX_W(FIDX_W), .DIST_W(DIST_W)) bus ();

    class_search_sched #(
        .N_CLASSES(N_CLASSES), .N_FRAMES(N_FRAMES), .FRAME_W(FRAME_W),
        .CID_W(CID_W), .FIDX_W(FIDX_W), .DIST_W(DIST_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] rom [N_CLASSES][N_FRAMES];
    logic [63:0] q   [N_FRAMES];
    int          exp_d [N_CLASSES];
    int          n_checks = 0;
    int          n_errors = 0;

    // stub ROM: combinational read of the addressed frame
    always_comb begin
        bus.rom_data = '0;
        if (int'(bus.frame_index) < N_FRAMES)
            bus.rom_data = rom[bus.frame_id][bus.frame_index];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] low_ones(input int n);
        logic [63:0] m;
        if (n >= 64) m = '1;
        else         m = (64'd1 << n) - 64'd1;
        return m;
    endfunction

    // each class differs from the query in exactly exp_d[c] bits
    task automatic build_rom();
        for (int c = 0; c < N_CLASSES; c++) begin
            int rem = exp_d[c];
            for (int f = 0; f < N_FRAMES; f++) begin
                int n = (rem > 64) ? 64 : rem;
                rom[c][f] = q[f] ^ low_ones(n);
                rem -= n;
            end
        end
    endtask

    task automatic set_dists(input int d0, d1, d2, d3, d4, d5, d6, d7);
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        exp_d[4] = d4; exp_d[5] = d5; exp_d[6] = d6; exp_d[7] = d7;
        build_rom();
    endtask

    task automatic load_query();
        for (int f = 0; f < N_FRAMES; f++) begin
            bus.q_valid = 1'b1;
            bus.q_frame = q[f];
            tick();
        end
        bus.q_valid = 1'b0;
    endtask

    // called right after edge E0; walks E1..E24 and checks the result
    task automatic run_scan(input bit sweep, input int ecls, input int edist);
        for (int k = 1; k <= N_CLASSES * N_FRAMES; k++) begin
            if (sweep)
                check("sweep", 64'({bus.frame_id, bus.frame_index}), 64'(((k - 1) / 3) * 4 + (k - 1) % 3));
            if (k == N_CLASSES * N_FRAMES)
                check("res_early", 64'(bus.res_valid), 64'd0);
            tick();
            check("cdv", 64'(bus.cls_dist_valid), 64'(k % 3 == 0));
            if (k % 3 == 0) begin
                check("cd_id", 64'(bus.cls_dist_id), 64'(k / 3 - 1));
                check("cd_dist", 64'(bus.cls_dist), 64'(exp_d[k / 3 - 1]));
            end
        end
        check("res_valid", 64'(bus.res_valid), 64'd1);
        check("res_class", 64'(bus.res_class), 64'(ecls));
        check("res_dist", 64'(bus.res_dist), 64'(edist));
        check("q_ready_done", 64'(bus.q_ready), 64'd0);
        check("busy_done", 64'(bus.busy), 64'd1);
        check("addr_done", 64'({bus.frame_id, bus.frame_index}), 64'd0);
    endtask

    task automatic accept_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("q_ready_after", 64'(bus.q_ready), 64'd1);
        check("res_valid_after", 64'(bus.res_valid), 64'd0);
        check("busy_after", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q_ready"}, 64'(bus.q_ready), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_addr"}, 64'({bus.frame_id, bus.frame_index}), 64'd0);
        check({tag, "_cdv"}, 64'(bus.cls_dist_valid), 64'd0);
        check({tag, "_cd"}, 64'({bus.cls_dist_id, bus.cls_dist}), 64'd0);
        check({tag, "_res"}, 64'({bus.res_valid, bus.res_class, bus.res_dist}), 64'd0);
    endtask

    initial begin
        bus.q_valid   = 1'b0;
        bus.q_frame   = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("rst");
        rst = 1'b0;
        tick();

        // class 5 matches exactly; full address sweep and result latency
        q[0] = 64'h0123_4567_89AB_CDEF;
        q[1] = 64'hFEDC_BA98_7654_3210;
        q[2] = 64'hA5A5_5A5A_C3C3_3C3C;
        set_dists(7, 3, 9, 12, 70, 0, 1, 130);
        load_query();
        run_scan(1'b1, 5, 0);
        accept_result();

        // tie at 10 between classes 2 and 6: lower id wins
        set_dists(15, 11, 10, 12, 13, 14, 10, 11);
        load_query();
        run_scan(1'b0, 2, 10);
        accept_result();

        // all-ones query against an all-zero ROM
        q[0] = '1; q[1] = '1; q[2] = '1;
        set_dists(192, 192, 192, 192, 192, 192, 192, 192);
        load_query();
        run_scan(1'b0, 0, 192);
        accept_result();

        // gapped query stream; distinct frames so misordering changes distances
        q[0] = 64'h1111_2222_3333_4444;
        q[1] = 64'h5555_6666_7777_8888;
        q[2] = 64'h9999_AAAA_BBBB_CCCC;
        set_dists(40, 33, 65, 129, 4, 9, 5, 100);
        begin
            automatic logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            automatic int f = 0;
            for (int i = 0; i < 6; i++) begin
                bus.q_valid = pat[i];
                bus.q_frame = pat[i] ? q[f] : 64'hDEAD_BEEF_DEAD_BEEF;
                if (pat[i]) f++;
                tick();
                check("busy_gap", 64'(bus.busy), 64'(i == 5));
            end
            bus.q_valid = 1'b0;
        end
        run_scan(1'b0, 4, 4);

        // backpressure: result held stable, no query accepted
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold", 64'({bus.res_valid, bus.q_ready, bus.res_class, bus.res_dist}), 64'({1'b1, 1'b0, 3'd4, 8'd4}));
        end
        accept_result();

        // back-to-back query right after the handshake
        set_dists(50, 60, 2, 70, 80, 90, 3, 1);
        load_query();
        run_scan(1'b0, 7, 1);
        accept_result();

        // reset in the middle of class 3
        set_dists(20, 21, 22, 23, 24, 25, 26, 27);
        load_query();
        for (int i = 0; i < 9; i++) tick();
        check("mid_scan_id", 64'(bus.frame_id), 64'd3);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) check("no_res_after_rst", 64'(bus.res_valid), 64'd0);
        end
        check("idle_after_rst", 64'({bus.res_valid, bus.q_ready, bus.busy}), 64'b010);

        // fresh query after reset must not see stale accumulators
        set_dists(30, 29, 28, 6, 31, 32, 33, 34);
        load_query();
        run_scan(1'b1, 3, 6);
        accept_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
